// File: rtl/loop_controller_pkg.sv
// Shared definitions for the bracket loop controller: opcode bytes and FSM state encoding.
`timescale 1ns/1ps
package loop_controller_pkg;

  localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_POP_WAIT = 2'd1,
    ST_SCAN     = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

endpackage

// File: rtl/loop_controller_scanner.sv
// Forward bracket scanner: streams instruction bytes one per cycle from a
// synchronous memory, tracks nesting and flags the matching ']' or a fault.
`timescale 1ns/1ps
module loop_controller_scanner #(
  parameter int ADDR_WIDTH = 11,
  parameter int NEST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_active,
  input  logic [7:0]            i_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_match,
  output logic [ADDR_WIDTH-1:0] o_match_addr,
  output logic                  o_fault
);
  import loop_controller_pkg::*;

  logic [ADDR_WIDTH-1:0] r_addr;     // address presented to memory this cycle
  logic [ADDR_WIDTH-1:0] r_rd_addr;  // address of the byte arriving this cycle
  logic                  r_rd_vld;   // a byte issued last cycle arrives now
  logic [NEST_WIDTH-1:0] r_nest;

  logic w_is_open;
  logic w_is_close;
  logic w_nest_ovf;
  logic w_wrap;

  assign w_is_open  = r_rd_vld && (i_data == OP_OPEN);
  assign w_is_close = r_rd_vld && (i_data == OP_CLOSE);

  assign o_match      = w_is_close && (r_nest == NEST_WIDTH'(1));
  assign o_match_addr = r_rd_addr;
  assign o_addr       = r_addr;

  // One more '[' with a saturated counter cannot be represented.
  assign w_nest_ovf = w_is_open && (&r_nest);
  // The last address has been examined without finding the match: going on would wrap.
  assign w_wrap     = r_rd_vld && (&r_rd_addr) && !o_match;
  assign o_fault    = w_nest_ovf || w_wrap;

  // Address generation, read tracking and nesting count; the read in flight at a match or fault is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_rd_addr <= '0;
      r_rd_vld  <= 1'b0;
      r_nest    <= '0;
    end else if (i_load) begin
      r_addr    <= i_pc + ADDR_WIDTH'(1);
      r_rd_addr <= '0;
      r_rd_vld  <= 1'b0;
      r_nest    <= NEST_WIDTH'(1);
    end else if (i_active && !o_match && !o_fault) begin
      r_rd_vld  <= 1'b1;
      r_rd_addr <= r_addr;
      // Park on the top address; its byte decides between match and wrap fault.
      if (!(&r_addr)) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
      if (w_is_open) begin
        r_nest <= r_nest + NEST_WIDTH'(1);
      end else if (w_is_close) begin
        r_nest <= r_nest - NEST_WIDTH'(1);
      end
    end else begin
      r_rd_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/loop_controller.sv
// Loop controller for '[' / ']' bracket instructions: pushes/pops the loop
// stack for taken loops and runs a forward scan to skip a loop whose cell is zero.
`timescale 1ns/1ps
module loop_controller #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH_POW  = 7,
  parameter int NEST_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  OPCODE_CLOSE,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  CELL_ZERO,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH-1:0] NEXT_PC,
  output logic                  ERROR,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic [7:0]            IMEM_DATA,
  output logic                  STK_PUSH,
  output logic                  STK_POP,
  output logic [ADDR_WIDTH-1:0] STK_D,
  input  logic [ADDR_WIDTH-1:0] STK_Q
);
  import loop_controller_pkg::*;

  state_e                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_next_pc;
  logic [DEPTH_POW:0]    r_level;    // 0 .. 2**DEPTH_POW inclusive
  logic [ADDR_WIDTH-1:0] r_lat_pc;
  logic                  r_lat_cz;

  logic                  w_accept;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_scan_load;
  logic                  w_match;
  logic                  w_scan_fault;
  logic [ADDR_WIDTH-1:0] w_match_addr;

  assign w_accept = START && (r_state == ST_IDLE);
  // Level never exceeds capacity, so the top bit alone marks a full stack.
  assign w_full   = r_level[DEPTH_POW];

  // Stack strobes fire in the START cycle itself; reset masks them immediately.
  assign w_push = RESET_N && w_accept && !OPCODE_CLOSE && !CELL_ZERO && !w_full;
  assign w_pop  = RESET_N && w_accept && OPCODE_CLOSE && (r_level != '0);

  // A '[' at the top address would start its scan past the end, so it faults instead.
  assign w_scan_load = w_accept && !OPCODE_CLOSE && CELL_ZERO && !(&PC);

  assign STK_PUSH = w_push;
  assign STK_POP  = w_pop;
  assign STK_D    = w_push ? PC : '0;

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign NEXT_PC = r_next_pc;
  assign ERROR   = r_error;

  loop_controller_scanner #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NEST_WIDTH (NEST_WIDTH)
  ) u_scanner (
    .clk          (CLK),
    .rst_n        (RESET_N),
    .i_load       (w_scan_load),
    .i_pc         (PC),
    .i_active     (r_state == ST_SCAN),
    .i_data       (IMEM_DATA),
    .o_addr       (IMEM_ADDR),
    .o_match      (w_match),
    .o_match_addr (w_match_addr),
    .o_fault      (w_scan_fault)
  );

  // Control FSM with registered BUSY/DONE/NEXT_PC/ERROR and the loop nesting level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_next_pc <= '0;
      r_level   <= '0;
      r_lat_pc  <= '0;
      r_lat_cz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // BUSY covers the DONE cycle and drops after it unless a new START is taken.
      if (r_done) begin
        r_busy <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            if (!OPCODE_CLOSE && !CELL_ZERO) begin
              if (w_full) begin
                r_state <= ST_FAULT;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_level   <= r_level + 1'b1;
                r_done    <= 1'b1;
                r_next_pc <= PC + ADDR_WIDTH'(1);
                r_busy    <= 1'b1;
              end
            end else if (!OPCODE_CLOSE) begin
              if (&PC) begin
                r_state <= ST_FAULT;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_SCAN;
                r_busy  <= 1'b1;
              end
            end else if (r_level == '0) begin
              r_state <= ST_FAULT;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_level  <= r_level - 1'b1;
              r_lat_pc <= PC;
              r_lat_cz <= CELL_ZERO;
              r_state  <= ST_POP_WAIT;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_POP_WAIT: begin
          // Loop taken: jump back to the '[' which re-pushes itself; else fall through.
          r_done    <= 1'b1;
          r_next_pc <= r_lat_cz ? (r_lat_pc + ADDR_WIDTH'(1)) : STK_Q;
          r_state   <= ST_IDLE;
        end
        ST_SCAN: begin
          if (w_scan_fault) begin
            r_state <= ST_FAULT;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_match) begin
            r_done    <= 1'b1;
            r_next_pc <= w_match_addr + ADDR_WIDTH'(1);
            r_state   <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/loop_controller.md
LOOP_CONTROLLER -- requirements
Module: LoopController

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the width of all program addresses and stack data.
REQ-002 Parameter DEPTH_POW, default 7, SHALL set the tracked stack capacity to 2**DEPTH_POW entries.
REQ-003 Parameter NEST_WIDTH, default 8, SHALL set the width of the forward-scan nesting counter.
REQ-004 CLK  in  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 RESET_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 START  in  1  SHALL be the one-cycle dispatch strobe for a bracket instruction.
REQ-007 OPCODE_CLOSE  in  1  SHALL select the opcode: 0 = '[', 1 = ']'; sampled with START.
REQ-008 PC  in  ADDR_WIDTH  SHALL be the address of the dispatched bracket; sampled with START.
REQ-009 CELL_ZERO  in  1  SHALL indicate that the current data cell is zero; sampled with START.
REQ-010 BUSY  out  1  SHALL be high from the cycle after an accepted START until DONE or fault.
REQ-011 DONE  out  1  SHALL be a one-cycle pulse qualifying NEXT_PC.
REQ-012 NEXT_PC  out  ADDR_WIDTH  SHALL be the core's next fetch address; valid only while DONE is high.
REQ-013 ERROR  out  1  SHALL be a sticky fault flag.
REQ-014 IMEM_ADDR  out  ADDR_WIDTH / IMEM_DATA  in  8  SHALL form a synchronous instruction-read port: data for the address presented in cycle n is returned in cycle n+1.
REQ-015 STK_PUSH, STK_POP  out  1 / STK_D  out  ADDR_WIDTH / STK_Q  in  ADDR_WIDTH  SHALL drive the loop stack. The stack contract is: a push stores STK_D; STK_Q holds the popped entry in the cycle after STK_POP.

Function
REQ-016 The FSM SHALL have the states IDLE, POP_WAIT, SCAN and FAULT; START SHALL be accepted only in IDLE and ignored otherwise.
REQ-017 '[' with CELL_ZERO=0 SHALL behave as follows.
- If LEVEL < 2**DEPTH_POW: assert STK_PUSH with STK_D=PC in the START cycle, increment LEVEL, and pulse DONE with NEXT_PC=PC+1 in the next cycle.
- Otherwise: enter FAULT.
REQ-018 ']' with LEVEL=0 SHALL enter FAULT without asserting STK_POP.
REQ-019 ']' with LEVEL>0 SHALL assert STK_POP in the START cycle, decrement LEVEL, and enter POP_WAIT.
REQ-020 In POP_WAIT the controller SHALL pulse DONE.
- NEXT_PC = STK_Q if the latched CELL_ZERO is 0; the matching '[' re-executes and re-pushes itself.
- NEXT_PC = latched PC+1 otherwise.
- The FSM then returns to IDLE.
REQ-021 '[' with CELL_ZERO=1 SHALL enter SCAN with nest=1 and scan address = PC+1, without touching the stack.
REQ-022 In SCAN the controller SHALL present a new IMEM_ADDR every cycle, giving a throughput of one character per cycle. Each returned byte SHALL be handled as follows.
- 0x5B: increment nest.
- 0x5D with nest>1: decrement nest.
- 0x5D with nest=1: pulse DONE with NEXT_PC = that byte's address + 1, then return to IDLE.
- Any other byte: ignore.
REQ-023 The read already in flight when the match is found SHALL be discarded.
REQ-024 SCAN SHALL enter FAULT on either of these conditions.
- The nest counter would overflow.
- The scan address would wrap past 2**ADDR_WIDTH-1.
REQ-025 FAULT SHALL hold ERROR=1, BUSY=0 and DONE=0, and strobe no stack or memory activity, until reset.
REQ-026 STK_PUSH and STK_POP SHALL never be asserted in the same cycle.
REQ-027 DONE SHALL never be asserted in the START cycle.
REQ-028 All address arithmetic SHALL be modulo 2**ADDR_WIDTH, except for the scan-wrap fault in REQ-024.

Reset
REQ-029 Asserting RESET_N low at any time, including mid-SCAN or in POP_WAIT, SHALL immediately force the following.
- State: IDLE.
- Outputs low: BUSY, DONE, ERROR, STK_PUSH, STK_POP.
- Zeroed: NEXT_PC, IMEM_ADDR, STK_D, LEVEL, nest.
REQ-030 The core SHALL hold the loop stack in reset whenever RESET_N is low, so that the stack pointer and LEVEL stay consistent.

Structure
REQ-031 A shared package/include SHALL hold the opcode constants OP_OPEN=0x5B and OP_CLOSE=0x5D and the FSM state encoding.
REQ-032 The forward scan SHALL be a sub-module, BracketScanner, holding the nest counter, scan address and wrap/overflow detection.

Verification
REQ-033 '[' at PC=0x010 with CELL_ZERO=0 -> STK_PUSH with STK_D=0x010; DONE next cycle with NEXT_PC=0x011; LEVEL=1.
REQ-034 That '[' followed by ']' at PC=0x014 with CELL_ZERO=0, STK_Q=0x010 -> STK_POP; DONE after 2 cycles with NEXT_PC=0x010.
REQ-035 Same sequence with CELL_ZERO=1 on the ']' -> DONE with NEXT_PC=0x015; LEVEL=0.
REQ-036 Memory "[+[-]>]x" at 0x020, START '[' at 0x020 with CELL_ZERO=1 -> DONE with NEXT_PC=0x027 exactly 8 cycles after START; no stack strobes.
REQ-037 ']' with LEVEL=0 -> ERROR=1 and no STK_POP; a later START is ignored; RESET_N low clears ERROR.
REQ-038 RESET_N low for 1 cycle mid-SCAN -> BUSY=0 immediately; the next '[' at 0x030 with CELL_ZERO=0 yields NEXT_PC=0x031.
